// File: rtl/ppu_pkg.sv
// Shared constants and types for the PPU framebuffer writer.
package ppu_pkg;

    localparam int LCD_W           = 160;
    localparam int LCD_H           = 144;
    localparam int FB_WORDS        = LCD_W * LCD_H / 4;
    localparam int DEF_FIFO_DEPTH  = 8;
    localparam int WORD_AW         = 13;

    typedef logic [1:0] shade_t;

    // One pending framebuffer write: target bank, word index and packed shades.
    typedef struct packed {
        logic               bank;
        logic [WORD_AW-1:0] addr;
        logic [7:0]         data;
    } fb_entry_t;

    // Palette lookup: shade = pal[2*idx+1 -: 2].
    function automatic shade_t pal_map(input logic [7:0] pal, input logic [1:0] idx);
        shade_t s;
        case (idx)
            2'd0:    s = pal[1:0];
            2'd1:    s = pal[3:2];
            2'd2:    s = pal[5:4];
            default: s = pal[7:6];
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ppu_fb_writer_if.sv
// Ready/valid write port from the framebuffer writer into framebuffer memory.
interface ppu_fb_writer_if;
    logic [13:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_we;
    logic        fb_ready;

    modport master (
        output fb_addr,
        output fb_data,
        output fb_we,
        input  fb_ready
    );

    modport slave (
        input  fb_addr,
        input  fb_data,
        input  fb_we,
        output fb_ready
    );
endinterface

// File: rtl/ppu_fb_writer_fifo.sv
// Small synchronous word FIFO; extra MSB on each pointer distinguishes full from empty.
// The head is read combinationally so a word pushed this cycle is visible next cycle.
module fb_word_fifo
    import ppu_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  fb_entry_t din,
    input  logic      pop,
    output fb_entry_t dout,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    fb_entry_t   mem [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push;
    logic        do_pop;

    // Status flags and pointer advance; a push while full is accepted only if a pop frees the slot.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers; reset empties the FIFO and drops its contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    assign dout = mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ppu_fb_writer.sv
// PPU framebuffer writer: palette-maps the pixel stream, packs 4 shades per byte
// and streams words into a double-buffered framebuffer through a word FIFO.
module ppu_fb_writer
    import ppu_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             px_in,
    input  logic                   px_valid,
    input  logic                   vblank,
    input  logic [7:0]             bgp,
    ppu_fb_writer_if.master        fb,
    output logic                   fb_bank,
    output logic                   frame_done,
    output logic                   overflow,
    output logic                   overrun
);

    localparam logic [7:0] X_LAST = 8'(LCD_W - 1);
    localparam logic [7:0] Y_LAST = 8'(LCD_H - 1);

    logic               vblank_q;
    logic               vblank_edge;
    logic [7:0]         x_q, x_d;
    logic [7:0]         y_q, y_d;
    logic [WORD_AW-1:0] word_addr_q, word_addr_d;
    logic [1:0]         pack_cnt_q, pack_cnt_d;
    logic [5:0]         pack_q, pack_d;
    logic               push_q, push_d;
    fb_entry_t          entry_q, entry_d;
    logic               bank_q, bank_d;
    logic               closed_q, closed_d;
    logic               frame_complete_q, frame_complete_d;
    logic               frame_done_q, frame_done_d;
    logic               overflow_q, overflow_d;
    logic               overrun_q, overrun_d;
    shade_t             shade;

    fb_entry_t          fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;

    fb_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_q),
        .din   (entry_q),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Write port: valid whenever the FIFO holds a word; outputs idle at zero when empty.
    assign fb.fb_we   = !fifo_empty;
    assign fb.fb_addr = fifo_empty ? 14'h0000 : {fifo_head.bank, fifo_head.addr};
    assign fb.fb_data = fifo_empty ? 8'h00 : fifo_head.data;
    assign fifo_pop   = !fifo_empty && fb.fb_ready;

    assign fb_bank    = bank_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign overrun    = overrun_q;

    // Frame control and pixel accept: the vblank edge is applied first so a pixel
    // arriving in the edge cycle lands at (0,0) of the new frame.
    always_comb begin
        vblank_edge      = vblank && !vblank_q;
        x_d              = x_q;
        y_d              = y_q;
        word_addr_d      = word_addr_q;
        pack_cnt_d       = pack_cnt_q;
        pack_d           = pack_q;
        push_d           = 1'b0;
        entry_d          = entry_q;
        bank_d           = bank_q;
        closed_d         = closed_q;
        frame_complete_d = frame_complete_q;
        frame_done_d     = 1'b0;
        overflow_d       = overflow_q;
        overrun_d        = overrun_q;
        shade            = pal_map(bgp, px_in);

        if (vblank_edge) begin
            x_d         = '0;
            y_d         = '0;
            word_addr_d = '0;
            pack_cnt_d  = '0;
            pack_d      = '0;
            closed_d    = 1'b0;
            if (frame_complete_q) begin
                bank_d           = !bank_q;
                frame_complete_d = 1'b0;
            end
        end else if (closed_q && fifo_empty && !push_q && !frame_complete_q) begin
            // Last word of the closed frame has left the FIFO.
            frame_done_d     = 1'b1;
            frame_complete_d = 1'b1;
        end

        if (px_valid) begin
            if (closed_d) begin
                overrun_d = 1'b1;
            end else begin
                if (pack_cnt_d == 2'd3) begin
                    push_d       = 1'b1;
                    entry_d.bank = bank_d;
                    entry_d.addr = word_addr_d;
                    entry_d.data = {pack_d, shade};
                    word_addr_d  = word_addr_d + 1'b1;
                    pack_cnt_d   = 2'd0;
                    pack_d       = '0;
                end else begin
                    pack_d     = {pack_d[3:0], shade};
                    pack_cnt_d = pack_cnt_d + 1'b1;
                end
                if (x_d == X_LAST) begin
                    x_d = '0;
                    if (y_d == Y_LAST) begin
                        y_d      = '0;
                        closed_d = 1'b1;
                    end else begin
                        y_d = y_d + 1'b1;
                    end
                end else begin
                    x_d = x_d + 1'b1;
                end
            end
        end

        // A word pushed into a full FIFO with no pop is lost.
        if (push_q && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vblank_q         <= 1'b0;
            x_q              <= '0;
            y_q              <= '0;
            word_addr_q      <= '0;
            pack_cnt_q       <= '0;
            pack_q           <= '0;
            push_q           <= 1'b0;
            entry_q          <= '0;
            bank_q           <= 1'b0;
            closed_q         <= 1'b0;
            frame_complete_q <= 1'b0;
            frame_done_q     <= 1'b0;
            overflow_q       <= 1'b0;
            overrun_q        <= 1'b0;
        end else begin
            vblank_q         <= vblank;
            x_q              <= x_d;
            y_q              <= y_d;
            word_addr_q      <= word_addr_d;
            pack_cnt_q       <= pack_cnt_d;
            pack_q           <= pack_d;
            push_q           <= push_d;
            entry_q          <= entry_d;
            bank_q           <= bank_d;
            closed_q         <= closed_d;
            frame_complete_q <= frame_complete_d;
            frame_done_q     <= frame_done_d;
            overflow_q       <= overflow_d;
            overrun_q        <= overrun_d;
        end
    end

endmodule
